// File: rtl/fp_alu_pkg.sv
// Shared types for the fp vector-mult ALU arbiter: FSM state encoding and requester ids.
package fp_alu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DP_BURST = 2'd1,
    VM_BURST = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  typedef enum logic {
    DP = 1'b0,
    VM = 1'b1
  } req_id_t;

  function automatic state_t burst_state(input req_id_t id);
    return (id == DP) ? DP_BURST : VM_BURST;
  endfunction

  function automatic req_id_t other_req(input req_id_t id);
    return (id == DP) ? VM : DP;
  endfunction

endpackage

// File: rtl/fp_alu_arbiter_if.sv
// Requester, ALU-drive and result-strobe signals of the fp ALU arbiter.
// slave = arbiter side; master = requesters plus the ALU.
interface fp_alu_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 7
);
  // valid/ready: a beat transfers on a rising clk edge where valid && ready are both
  // high; valid never waits on ready, and payload/last are held while valid && !ready.
  logic                          dp_req_valid;
  logic                          dp_req_last;
  logic                          dp_req_ready;
  logic [WIDTH*NUM_INPUTS-1:0]   dp_req_a;
  logic [WIDTH*NUM_INPUTS-1:0]   dp_req_b;
  logic [WIDTH-1:0]              dp_req_c;
  logic [NUM_INPUTS-1:0]         dp_req_enable;

  logic                          vm_req_valid;
  logic                          vm_req_last;
  logic                          vm_req_ready;
  logic [WIDTH*NUM_INPUTS-1:0]   vm_req_a;
  logic [WIDTH*NUM_INPUTS-1:0]   vm_req_b;

  logic                          alu_ready;
  logic                          alu_dot_product_mode;
  logic [NUM_INPUTS-1:0]         alu_dot_product_enable;
  logic [WIDTH*NUM_INPUTS-1:0]   alu_a;
  logic [WIDTH*NUM_INPUTS-1:0]   alu_b;
  logic [WIDTH-1:0]              alu_c;
  logic                          alu_dot_product_valid;
  logic                          alu_vector_mult_valid;

  logic                          dp_resp_valid;
  logic                          vm_resp_valid;

  modport slave (
    input  dp_req_valid, dp_req_last, dp_req_a, dp_req_b, dp_req_c, dp_req_enable,
    input  vm_req_valid, vm_req_last, vm_req_a, vm_req_b,
    input  alu_dot_product_valid, alu_vector_mult_valid,
    output dp_req_ready, vm_req_ready,
    output alu_ready, alu_dot_product_mode, alu_dot_product_enable, alu_a, alu_b, alu_c,
    output dp_resp_valid, vm_resp_valid
  );

  modport master (
    output dp_req_valid, dp_req_last, dp_req_a, dp_req_b, dp_req_c, dp_req_enable,
    output vm_req_valid, vm_req_last, vm_req_a, vm_req_b,
    output alu_dot_product_valid, alu_vector_mult_valid,
    input  dp_req_ready, vm_req_ready,
    input  alu_ready, alu_dot_product_mode, alu_dot_product_enable, alu_a, alu_b, alu_c,
    input  dp_resp_valid, vm_resp_valid
  );

endinterface

// File: rtl/fp_alu_credit_counter.sv
// Tracks ALU results in flight; sticky err_underflow when a result arrives with none outstanding.
module fp_alu_credit_counter #(
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inc,
  input  logic                                 dec,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] count,
  output logic                                 err_underflow
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  // inc is gated upstream by count < MAX_OUTSTANDING, so no overflow guard is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      err_underflow <= 1'b0;
    end else if (inc && !dec) begin
      count <= count + CW'(1);
    end else if (dec && !inc) begin
      if (count == '0) err_underflow <= 1'b1;
      else             count         <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fp_alu_arbiter.sv
// Arbitrates a dot-product and a vector-mult requester onto one shared fp_vector_mult_alu,
// whole bursts at a time. Optional counters: define FP_ALU_ARBITER_PERF_EN.
module fp_alu_arbiter
  import fp_alu_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int NUM_INPUTS      = 7,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  fp_alu_arbiter_if.slave                      bus,
  output logic                                 err_underflow,
  output state_t                               dbg_state,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_outstanding
`ifdef FP_ALU_ARBITER_PERF_EN
  ,
  output logic [31:0]                          perf_mode_switches,
  output logic [31:0]                          perf_stall_cycles
`endif
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  state_t        state, state_next;
  req_id_t       grant_id, grant_next;
  req_id_t       rr_ptr, rr_next;
  req_id_t       pick;
  logic          mode, mode_next;
  logic [CW-1:0] outstanding;
  logic          drained, credit_ok;
  logic          dp_ready, vm_ready, dp_accept, vm_accept;
  logic          inc, dec;

  assign drained   = (outstanding == '0);
  assign credit_ok = (outstanding < CW'(MAX_OUTSTANDING));
  assign dp_ready  = (state == DP_BURST) && credit_ok;
  assign vm_ready  = (state == VM_BURST) && credit_ok;
  assign dp_accept = bus.dp_req_valid && dp_ready;
  assign vm_accept = bus.vm_req_valid && vm_ready;
  assign inc       = dp_accept || vm_accept;
  // Only strobes of the mode currently programmed into the ALU retire credits.
  assign dec       = mode ? bus.alu_dot_product_valid : bus.alu_vector_mult_valid;

  fp_alu_credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .inc           (inc),
    .dec           (dec),
    .count         (outstanding),
    .err_underflow (err_underflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= DP;
      rr_ptr   <= DP;
      mode     <= 1'b0;
    end else begin
      state    <= state_next;
      grant_id <= grant_next;
      rr_ptr   <= rr_next;
      mode     <= mode_next;
    end
  end

  // rr_ptr names the requester that wins the next tie.
  always_comb begin
    if (bus.dp_req_valid && bus.vm_req_valid) pick = rr_ptr;
    else if (bus.dp_req_valid)                pick = DP;
    else                                      pick = VM;
  end

  always_comb begin
    state_next = state;
    grant_next = grant_id;
    rr_next    = rr_ptr;
    mode_next  = mode;
    case (state)
      IDLE: begin
        if (bus.dp_req_valid || bus.vm_req_valid) begin
          grant_next = pick;
          rr_next    = other_req(pick);
          if (drained) begin
            mode_next  = (pick == DP);
            state_next = burst_state(pick);
          end else if (mode == (pick == DP)) begin
            state_next = burst_state(pick);
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The mode may only flip once every result of the old mode is back.
        if (drained) begin
          mode_next  = (grant_id == DP);
          state_next = burst_state(grant_id);
        end
      end
      DP_BURST: if (dp_accept && bus.dp_req_last) state_next = IDLE;
      VM_BURST: if (vm_accept && bus.vm_req_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.alu_a                  = '0;
    bus.alu_b                  = '0;
    bus.alu_c                  = '0;
    bus.alu_dot_product_enable = '0;
    case (state)
      DP_BURST: begin
        bus.alu_a                  = bus.dp_req_a;
        bus.alu_b                  = bus.dp_req_b;
        bus.alu_c                  = bus.dp_req_c;
        bus.alu_dot_product_enable = bus.dp_req_enable;
      end
      VM_BURST: begin
        bus.alu_a = bus.vm_req_a;
        bus.alu_b = bus.vm_req_b;
      end
      default: ;
    endcase
  end

  assign bus.dp_req_ready         = dp_ready;
  assign bus.vm_req_ready         = vm_ready;
  assign bus.alu_ready            = inc;
  assign bus.alu_dot_product_mode = mode;
  assign bus.dp_resp_valid        = bus.alu_dot_product_valid;
  assign bus.vm_resp_valid        = bus.alu_vector_mult_valid;

  assign dbg_state       = state;
  assign dbg_outstanding = outstanding;

`ifdef FP_ALU_ARBITER_PERF_EN
  logic stall;

  assign stall = (state == DRAIN)
              || ((state == DP_BURST) && bus.dp_req_valid && !credit_ok)
              || ((state == VM_BURST) && bus.vm_req_valid && !credit_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mode_switches <= '0;
      perf_stall_cycles  <= '0;
    end else begin
      if ((mode_next != mode) && (perf_mode_switches != '1))
        perf_mode_switches <= perf_mode_switches + 32'd1;
      if (stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed bench for fp_alu_arbiter: arbitration table plus burst, drain, credit, reset
// and underflow sequences against a fixed-latency ALU stand-in.
module tb_fp_alu_arbiter;
  import fp_alu_pkg::*;

  localparam int W = 32;
  localparam int N = 7;
  localparam int V = W * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_alu_arbiter_if #(.WIDTH(W), .NUM_INPUTS(N)) bus ();
  fp_alu_arbiter_if #(.WIDTH(W), .NUM_INPUTS(N)) bus2 ();

  logic       err1, err2;
  state_t     st1, st2;
  logic [5:0] out1;
  logic [1:0] out2;
`ifdef FP_ALU_ARBITER_PERF_EN
  logic [31:0] pms1, psc1, pms2, psc2;
`endif

  fp_alu_arbiter #(.WIDTH(W), .NUM_INPUTS(N), .MAX_OUTSTANDING(32)) dut (
    .clk (clk), .rst (rst), .bus (bus), .err_underflow (err1),
    .dbg_state (st1), .dbg_outstanding (out1)
`ifdef FP_ALU_ARBITER_PERF_EN
    , .perf_mode_switches (pms1), .perf_stall_cycles (psc1)
`endif
  );

  fp_alu_arbiter #(.WIDTH(W), .NUM_INPUTS(N), .MAX_OUTSTANDING(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2), .err_underflow (err2),
    .dbg_state (st2), .dbg_outstanding (out2)
`ifdef FP_ALU_ARBITER_PERF_EN
    , .perf_mode_switches (pms2), .perf_stall_cycles (psc2)
`endif
  );

  // ALU stand-ins: fixed-latency delay lines of accepted beats, split by mode, cleared by rst.
  int          lat1 = 19;
  logic        force_vm;
  logic [31:0] pdp1, pvm1, pdp2, pvm2;

  always @(posedge clk) begin
    if (rst) begin
      pdp1 <= '0; pvm1 <= '0; pdp2 <= '0; pvm2 <= '0;
    end else begin
      pdp1 <= {pdp1[30:0], bus.alu_ready & bus.alu_dot_product_mode};
      pvm1 <= {pvm1[30:0], bus.alu_ready & ~bus.alu_dot_product_mode};
      pdp2 <= {pdp2[30:0], bus2.alu_ready & bus2.alu_dot_product_mode};
      pvm2 <= {pvm2[30:0], bus2.alu_ready & ~bus2.alu_dot_product_mode};
    end
  end

  assign bus.alu_dot_product_valid  = pdp1[lat1-1];
  assign bus.alu_vector_mult_valid  = pvm1[lat1-1] | force_vm;
  assign bus2.alu_dot_product_valid = pdp2[9];
  assign bus2.alu_vector_mult_valid = pvm2[9];

  // Result-strobe and occupancy monitor, sampled mid-cycle.
  int dp_cnt1, vm_cnt1, vm_cnt2, peak1, peak2;
  always @(negedge clk) begin
    if (rst) begin
      dp_cnt1 = 0; vm_cnt1 = 0; vm_cnt2 = 0; peak1 = 0; peak2 = 0;
    end else begin
      if (bus.dp_resp_valid)  dp_cnt1++;
      if (bus.vm_resp_valid)  vm_cnt1++;
      if (bus2.vm_resp_valid) vm_cnt2++;
      if (int'(out1) > peak1) peak1 = int'(out1);
      if (int'(out2) > peak2) peak2 = int'(out2);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.dp_req_valid = 1'b0; bus.dp_req_last = 1'b0; bus.dp_req_a = '0; bus.dp_req_b = '0;
    bus.dp_req_c = '0; bus.dp_req_enable = '0;
    bus.vm_req_valid = 1'b0; bus.vm_req_last = 1'b0; bus.vm_req_a = '0; bus.vm_req_b = '0;
    bus2.dp_req_valid = 1'b0; bus2.dp_req_last = 1'b0; bus2.dp_req_a = '0; bus2.dp_req_b = '0;
    bus2.dp_req_c = '0; bus2.dp_req_enable = '0;
    bus2.vm_req_valid = 1'b0; bus2.vm_req_last = 1'b0; bus2.vm_req_a = '0; bus2.vm_req_b = '0;
    force_vm = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((out1 != 6'd0 || st1 != IDLE) && n < 100) begin
      tick();
      n++;
    end
    chk(name, out1, 0);
  endtask

  typedef struct {
    logic   dp_v;
    logic   vm_v;
    state_t exp_state;
    logic   exp_mode;
  } arb_vec_t;

  arb_vec_t        tbl[8];
  logic [31:0]     cvals[8];
  logic [W-1:0]    exp_q[$];
  logic [31:0]     pat;
  logic [V-1:0]    dpa, vma;
  logic [N-1:0]    en_exp;
  logic            exp_dp, acc, stall_seen;
  int              beat, n, viol;

  initial begin
    tbl[0] = '{1'b1, 1'b1, DP_BURST, 1'b1};
    tbl[1] = '{1'b1, 1'b1, VM_BURST, 1'b0};
    tbl[2] = '{1'b1, 1'b1, DP_BURST, 1'b1};
    tbl[3] = '{1'b1, 1'b0, DP_BURST, 1'b1};
    tbl[4] = '{1'b0, 1'b1, VM_BURST, 1'b0};
    tbl[5] = '{1'b1, 1'b1, DP_BURST, 1'b1};
    tbl[6] = '{1'b0, 1'b1, VM_BURST, 1'b0};
    tbl[7] = '{1'b1, 1'b1, DP_BURST, 1'b1};
    cvals[0] = 32'h3F80_0000; cvals[1] = 32'h4000_0000; cvals[2] = 32'h4040_0000;
    cvals[3] = 32'h4080_0000; cvals[4] = 32'h40A0_0000; cvals[5] = 32'h40C0_0000;
    cvals[6] = 32'h40E0_0000; cvals[7] = 32'h4100_0000;

    // Reset state
    lat1 = 19;
    do_reset();
    chk("rst_state", st1, IDLE);
    chk("rst_outstanding", out1, 0);
    chk("rst_err", err1, 0);
    chk("rst_mode", bus.alu_dot_product_mode, 0);
    chk("rst_dp_ready", bus.dp_req_ready, 0);
    chk("rst_vm_ready", bus.vm_req_ready, 0);
    chk("rst_alu_ready", bus.alu_ready, 0);
    chk("rst_enable", bus.alu_dot_product_enable, 0);

    // vm-only burst of 4 beats, latency 19
    bus.vm_req_valid = 1'b1;
    tick();
    chk("vm4_grant", st1, VM_BURST);
    for (int b = 0; b < 4; b++) begin
      bus.vm_req_last = (b == 3);
      pat = 32'h2000_0000 + 32'(b);
      bus.vm_req_a = {N{pat}};
      #1;
      chk("vm4_ready", bus.vm_req_ready, 1);
      chk("vm4_alu_a", bus.alu_a, {N{pat}});
      tick();
    end
    bus.vm_req_valid = 1'b0;
    n = 0;
    while ((vm_cnt1 < 4 || out1 != 6'd0) && n < 60) begin tick(); n++; end
    chk("vm4_resp_count", vm_cnt1, 4);
    chk("vm4_peak", peak1, 4);
    chk("vm4_outstanding_end", out1, 0);
    chk("vm4_mode", bus.alu_dot_product_mode, 0);

    // dp burst of 8 then vm burst: drain before the mode flips
    do_reset();
    bus.dp_req_valid = 1'b1;
    tick();
    chk("dp8_grant", st1, DP_BURST);
    chk("dp8_mode", bus.alu_dot_product_mode, 1);
    for (int b = 0; b < 8; b++) begin
      en_exp = N'((1 << b) - 1);
      bus.dp_req_enable = en_exp;
      bus.dp_req_c = cvals[b];
      bus.dp_req_last = (b == 7);
      exp_q.push_back(cvals[b]);
      #1;
      chk("dp8_ready", bus.dp_req_ready, 1);
      chk("dp8_enable", bus.alu_dot_product_enable, en_exp);
      chk("dp8_alu_c", bus.alu_c, exp_q.pop_front());
      tick();
    end
    bus.dp_req_valid = 1'b0;
    bus.vm_req_valid = 1'b1;
    bus.vm_req_last  = 1'b1;
    tick();
    chk("dp8_drain", st1, DRAIN);
    chk("dp8_drain_vm_ready", bus.vm_req_ready, 0);
    chk("dp8_drain_alu_ready", bus.alu_ready, 0);
    n = 0;
    while (bus.alu_dot_product_mode == 1'b1 && n < 80) begin tick(); n++; end
    chk("dp8_resp_before_switch", dp_cnt1, 8);
    chk("dp8_after_switch_state", st1, VM_BURST);
    chk("dp8_vm_ready", bus.vm_req_ready, 1);
    tick();
    bus.vm_req_valid = 1'b0;
    wait_drained("dp8_vm_drained");
    chk("dp8_err", err1, 0);
`ifdef FP_ALU_ARBITER_PERF_EN
    chk("dp8_perf_switches", pms1, 2);
`endif

    // Arbitration table, latency 2, each grant from a drained ALU
    lat1 = 2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pat = 32'h1000_0000 + 32'(i);
      dpa = {N{pat}};
      pat = 32'h2000_0000 + 32'(i);
      vma = {N{pat}};
      bus.dp_req_a = dpa;     bus.vm_req_a = vma;
      bus.dp_req_last = 1'b1; bus.vm_req_last = 1'b1;
      bus.dp_req_valid = tbl[i].dp_v;
      bus.vm_req_valid = tbl[i].vm_v;
      tick();
      exp_dp = (tbl[i].exp_state == DP_BURST);
      chk($sformatf("tbl%0d_state", i), st1, tbl[i].exp_state);
      chk($sformatf("tbl%0d_mode", i), bus.alu_dot_product_mode, tbl[i].exp_mode);
      chk($sformatf("tbl%0d_dp_ready", i), bus.dp_req_ready, exp_dp);
      chk($sformatf("tbl%0d_vm_ready", i), bus.vm_req_ready, !exp_dp);
      chk($sformatf("tbl%0d_alu_ready", i), bus.alu_ready, 1);
      chk($sformatf("tbl%0d_alu_a", i), bus.alu_a, exp_dp ? dpa : vma);
      tick();
      bus.dp_req_valid = 1'b0;
      bus.vm_req_valid = 1'b0;
      chk($sformatf("tbl%0d_idle", i), st1, IDLE);
      wait_drained($sformatf("tbl%0d_drained", i));
    end

    // MAX_OUTSTANDING = 2, 5-beat vm burst, latency 10
    do_reset();
    bus2.vm_req_valid = 1'b1;
    tick();
    chk("cr_grant", st2, VM_BURST);
    beat = 0; n = 0; viol = 0; stall_seen = 1'b0;
    while (beat < 5 && n < 200) begin
      bus2.vm_req_last = (beat == 4);
      #1;
      if (bus2.vm_req_ready && out2 == 2'd2) viol++;
      if (!bus2.vm_req_ready && beat == 2) stall_seen = 1'b1;
      acc = bus2.vm_req_ready;
      tick();
      n++;
      if (acc) beat++;
      if (beat == 5) bus2.vm_req_valid = 1'b0;
    end
    n = 0;
    while ((vm_cnt2 < 5 || out2 != 2'd0) && n < 100) begin tick(); n++; end
    chk("cr_beats", beat, 5);
    chk("cr_stall_seen", stall_seen, 1);
    chk("cr_ready_at_max", viol, 0);
    chk("cr_peak", peak2, 2);
    chk("cr_results", vm_cnt2, 5);
    chk("cr_outstanding_end", out2, 0);

    // Reset three beats into a dp burst
    lat1 = 19;
    do_reset();
    pat = 32'h3F80_0000;
    bus.dp_req_a = {N{pat}}; bus.dp_req_c = pat; bus.dp_req_enable = '1;
    bus.dp_req_valid = 1'b1;
    tick();
    tick(); tick(); tick();
    chk("rb_outstanding_before", out1, 3);
    rst = 1'b1;
    bus.dp_req_valid = 1'b0;
    tick();
    chk("rb_state", st1, IDLE);
    chk("rb_outstanding", out1, 0);
    chk("rb_mode", bus.alu_dot_product_mode, 0);
    chk("rb_dp_ready", bus.dp_req_ready, 0);
    chk("rb_alu_ready", bus.alu_ready, 0);
    chk("rb_alu_a", bus.alu_a, 0);
    chk("rb_alu_c", bus.alu_c, 0);
    chk("rb_enable", bus.alu_dot_product_enable, 0);
    chk("rb_dp_resp", bus.dp_resp_valid, 0);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    chk("rb_no_dp_resp", dp_cnt1, 0);
    chk("rb_no_vm_resp", vm_cnt1, 0);

    // Underflow: result strobe with nothing outstanding
    do_reset();
    chk("uf_err_before", err1, 0);
    force_vm = 1'b1;
    tick();
    force_vm = 1'b0;
    chk("uf_err", err1, 1);
    chk("uf_count", out1, 0);
    tick(); tick();
    chk("uf_sticky", err1, 1);
    do_reset();
    chk("uf_cleared", err1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_alu_arbiter.md
FP_ALU_ARBITER -- requirements
Module: fp_alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, float element width.
REQ-002 Parameter NUM_INPUTS, default 7, vector length of the shared fp_vector_mult_alu.
REQ-003 Parameter MAX_OUTSTANDING, default 32, maximum ALU results in flight.
REQ-004 clk  in  1  single clock; rst  in  1  synchronous, active-high reset.
REQ-005 dp_req_valid, dp_req_last  in  1 each; dp_req_ready  out  1  dot-product requester handshake.
REQ-006 dp_req_a, dp_req_b  in  WIDTH*NUM_INPUTS; dp_req_c  in  WIDTH; dp_req_enable  in  NUM_INPUTS  dot-product beat payload.
REQ-007 vm_req_valid, vm_req_last  in  1 each; vm_req_ready  out  1; vm_req_a, vm_req_b  in  WIDTH*NUM_INPUTS  vector-mult requester.
REQ-008 alu_ready, alu_dot_product_mode  out  1; alu_dot_product_enable  out  NUM_INPUTS; alu_a, alu_b  out  WIDTH*NUM_INPUTS; alu_c  out  WIDTH  drive the ALU.
REQ-009 alu_dot_product_valid, alu_vector_mult_valid  in  1  ALU result strobes.
REQ-010 dp_resp_valid  out  1; vm_resp_valid  out  1  result strobes returned to the owning requester.

Function
REQ-011 FSM states IDLE, DP_BURST, VM_BURST, DRAIN; the arbiter SHALL own the ALU for one whole burst (valid beats up to and including the one with last).
REQ-012 IDLE: one requester valid -> grant it; both valid -> grant the one not granted last (round-robin, dp wins the first tie after reset).
REQ-013 A grant whose mode equals alu_dot_product_mode, or with outstanding==0, SHALL enter the burst state the next cycle; otherwise DRAIN until outstanding==0, then the burst state.
REQ-014 alu_dot_product_mode SHALL change only when outstanding==0; it holds its last value in IDLE and DRAIN.
REQ-015 In a burst state, req_ready = 1 iff outstanding < MAX_OUTSTANDING; alu_ready = req_valid && req_ready (combinational), and alu_a/b/c/enable mirror the granted payload.
REQ-016 A beat is accepted when valid && ready; accepting last SHALL return the FSM to IDLE the next cycle; a bubble (valid low) keeps the grant.
REQ-017 outstanding counter, width clog2(MAX_OUTSTANDING+1): +1 per accepted beat, -1 per ALU valid strobe of the current mode, unchanged when both occur in the same cycle.
REQ-018 dp_resp_valid = alu_dot_product_valid; vm_resp_valid = alu_vector_mult_valid; result data is taken directly from the ALU by requesters.
REQ-019 ALU valid with outstanding==0 SHALL leave the counter at 0 and set sticky err_underflow (out, 1).
REQ-020 Non-granted requester's ready SHALL be 0; alu_ready, alu enable SHALL be 0 outside burst states.

Reset
REQ-021 On rst: FSM IDLE, outstanding 0, round-robin pointer to dp, all outputs 0 (alu_dot_product_mode 0, err_underflow 0).
REQ-022 rst mid-burst or mid-drain SHALL abandon the burst; the ALU SHALL share the same rst so no stale results return.

Configuration
REQ-023 Macro FP_ALU_ARBITER_PERF_EN defined: outputs perf_mode_switches (32 b, +1 per mode change) and perf_stall_cycles (32 b, +1 per cycle a granted requester is valid but not ready or FSM is in DRAIN), both cleared by rst, saturating.
REQ-024 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-025 Shared package fp_alu_pkg SHALL hold the FSM state enum and the requester-id typedef (DP, VM).
REQ-026 One sub-module fp_alu_credit_counter SHALL implement the outstanding counter and underflow flag; the FSM and muxing stay in the top.

Verification
REQ-027 vm-only burst of 4 beats, ALU latency 19 -> alu_dot_product_mode 0, vm_resp_valid 4 times, outstanding peaks at 4 and returns to 0.
REQ-028 dp burst of 8 beats (enable ramp 0x00,0x01..0x7F, c=1.0..8.0) then vm burst -> DRAIN entered, mode switches 1->0 only after 8th dp_resp_valid.
REQ-029 both valid at same cycle in IDLE, twice -> grants dp then vm (then dp again on third tie).
REQ-030 MAX_OUTSTANDING=2, 5-beat vm burst, ALU latency 10 -> vm_req_ready low after 2 beats until results return; all 5 results delivered.
REQ-031 rst asserted 3 cycles into a dp burst -> next cycle all outputs 0, FSM IDLE, outstanding 0, no resp_valid afterwards.
REQ-032 Forced alu_vector_mult_valid with outstanding 0 -> err_underflow 1, counter stays 0; with FP_ALU_ARBITER_PERF_EN, REQ-028 yields perf_mode_switches = 2.
